// File: rtl/height_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : height_bcd_converter
// Brief    : Iterative shift-add-3 (double-dabble) binary-to-BCD converter
//            for the measured height value. Results are published to the
//            digit outputs only at conversion end, together with a one-cycle
//            done pulse, so the downstream glyph stage never sees a partial
//            value. Inputs above 10^NUM_DIGITS-1 saturate and flag overflow.
// Options  : HEIGHT_BCD_LEADING_ZERO_BLANK_EN - replace leading zero digits
//            (never digit 0) with 4'hF, the background glyph code.
// Revision : 1.0 - initial release
// ============================================================================
module height_bcd_converter #(
  parameter int BIN_WIDTH  = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    overflow
);

  // Decimal ceiling 10^n, evaluated at elaboration time.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam int                   SW       = 4 * NUM_DIGITS;
  localparam int                   CW       = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0]          MAX_VAL  = pow10(NUM_DIGITS) - 64'd1;
  // Only used when the input exceeds MAX_VAL, which implies MAX_VAL fits.
  localparam logic [BIN_WIDTH-1:0] MAX_BIN  = MAX_VAL[BIN_WIDTH-1:0];
  localparam logic [CW-1:0]        CNT_INIT = CW'(BIN_WIDTH);

`ifdef HEIGHT_BCD_LEADING_ZERO_BLANK_EN
  localparam logic [SW-1:0] DIGITS_RST = {SW{1'b1}};
`else
  localparam logic [SW-1:0] DIGITS_RST = '0;
`endif

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   overflow_q;
  logic                   ovf_pend_q;
  logic [SW-1:0]          digits_q;
  logic [SW-1:0]          scratch_q;
  logic [BIN_WIDTH-1:0]   bin_q;
  logic [CW-1:0]          cnt_q;

  logic                   over_range;
  logic [SW-1:0]          scratch_adj;
  logic [SW-1:0]          scratch_d;
  logic [SW-1:0]          digits_d;

  assign over_range = (64'(bin_in) > MAX_VAL);

  // Add-3 correction on every nibble that would reach 10+ after doubling.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    assign scratch_adj[4*g +: 4] = (scratch_q[4*g +: 4] >= 4'd5) ?
                                   (scratch_q[4*g +: 4] + 4'd3) :
                                   scratch_q[4*g +: 4];
  end

  // Corrected scratch shifted left, pulling in the next binary MSB.
  assign scratch_d = {scratch_adj[SW-2:0], bin_q[BIN_WIDTH-1]};

`ifdef HEIGHT_BCD_LEADING_ZERO_BLANK_EN
  // Blank every digit above the most significant nonzero one; digit 0 stays.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    digits_d = scratch_d;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (scratch_d[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      if (!seen) begin
        digits_d[4*i +: 4] = 4'hF;
      end
    end
  end
`else
  // Leading zeros are published as plain zero digits.
  always_comb begin
    digits_d = scratch_d;
  end
`endif

  // Conversion FSM: capture on start, shift BIN_WIDTH times, publish once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      digits_q   <= DIGITS_RST;
      scratch_q  <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_CONVERT;
            busy_q     <= 1'b1;
            bin_q      <= over_range ? MAX_BIN : bin_in;
            ovf_pend_q <= over_range;
            scratch_q  <= '0;
            cnt_q      <= CNT_INIT;
          end
        end
        S_CONVERT: begin
          scratch_q <= scratch_d;
          bin_q     <= bin_q << 1;
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            digits_q   <= digits_d;
            overflow_q <= ovf_pend_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_height_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_height_bcd_converter
// Brief    : Self-checking bench for height_bcd_converter. Drives a 4-digit
//            and a 3-digit instance with identical stimulus and compares both
//            against an arithmetic decimal reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_height_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  bin_in;

  logic        busy4, done4, ovf4;
  logic [15:0] dig4;
  logic        busy3, done3, ovf3;
  logic [11:0] dig3;

  int checks   = 0;
  int failures = 0;

  logic [15:0] e4, e3;
  logic        eo4, eo3;

  always #5 clk = ~clk;

  height_bcd_converter #(.BIN_WIDTH(10), .NUM_DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy4), .done(done4), .digits(dig4), .overflow(ovf4)
  );

  height_bcd_converter #(.BIN_WIDTH(10), .NUM_DIGITS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy3), .done(done3), .digits(dig3), .overflow(ovf3)
  );

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Decimal digits of the saturated value, leading digits blanked if enabled.
  function automatic logic [15:0] ref_dig(input int v, input int nd);
    int s;
    logic [15:0] r;
    s = (v > p10(nd) - 1) ? p10(nd) - 1 : v;
    r = '0;
    for (int d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'((s / p10(d)) % 10);
`ifdef HEIGHT_BCD_LEADING_ZERO_BLANK_EN
      if (d > 0 && s < p10(d)) r[4*d +: 4] = 4'hF;
`endif
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_rst(input int nd);
    logic [15:0] r;
    r = '0;
`ifdef HEIGHT_BCD_LEADING_ZERO_BLANK_EN
    for (int d = 0; d < nd; d++) r[4*d +: 4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle-cycle checks: no pulse, not busy, results held.
  task automatic chk_idle(input string tag);
    chk({tag, "_done4"}, 16'(done4), 16'd0);
    chk({tag, "_busy4"}, 16'(busy4), 16'd0);
    chk({tag, "_dig4"},  dig4, e4);
    chk({tag, "_ovf4"},  16'(ovf4), 16'(eo4));
    chk({tag, "_done3"}, 16'(done3), 16'd0);
    chk({tag, "_dig3"},  {4'h0, dig3}, e3);
    chk({tag, "_ovf3"},  16'(ovf3), 16'(eo3));
  endtask

  // Called at a negedge with both DUTs idle (or in their done cycle).
  // Returns at the negedge of the done cycle after checking the result.
  task automatic convert(input int v, input int glitch_at, input int glitch_v);
    start  = 1'b1;
    bin_in = 10'(v);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("cv_busy4", 16'(busy4), 16'd1);
      chk("cv_done4", 16'(done4), 16'd0);
      chk("cv_hold4", dig4, e4);
      chk("cv_busy3", 16'(busy3), 16'd1);
      chk("cv_hold3", {4'h0, dig3}, e3);
      if (i == glitch_at) begin
        start  = 1'b1;
        bin_in = 10'(glitch_v);
      end else begin
        start  = 1'b0;
        bin_in = 10'($urandom_range(0, 1023));
      end
      @(negedge clk);
    end
    start = 1'b0;
    e4  = ref_dig(v, 4);
    eo4 = (v > 9999);
    e3  = ref_dig(v, 3);
    eo3 = (v > 999);
    chk("res_done4", 16'(done4), 16'd1);
    chk("res_busy4", 16'(busy4), 16'd0);
    chk("res_dig4",  dig4, e4);
    chk("res_ovf4",  16'(ovf4), 16'(eo4));
    chk("res_done3", 16'(done3), 16'd1);
    chk("res_busy3", 16'(busy3), 16'd0);
    chk("res_dig3",  {4'h0, dig3}, e3);
    chk("res_ovf3",  16'(ovf3), 16'(eo3));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_idle("idle");
    end
  endtask

  initial begin
    int v;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    e4  = ref_rst(4);
    e3  = ref_rst(3);
    eo4 = 1'b0;
    eo3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    reset = 1'b0;
    @(negedge clk);

    // Full-range value, then zero with single-pulse check.
    convert(1023, -1, 0);
    idle_cycles(2);
    convert(0, -1, 0);
    idle_cycles(2);

    // Back-to-back: start held in the done cycle.
    convert(57, -1, 0);
    convert(999, -1, 0);
    idle_cycles(2);

    // Start while busy is ignored; no extra done afterwards.
    convert(123, 3, 456);
    idle_cycles(12);

    // Saturation on the 3-digit instance, then a small value clears it.
    convert(1000, -1, 0);
    idle_cycles(1);
    convert(5, -1, 0);
    idle_cycles(1);
    convert(1000, -1, 0);
    idle_cycles(1);

    // Reset during the fourth CONVERT cycle aborts the conversion.
    start  = 1'b1;
    bin_in = 10'd321;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    e4  = ref_rst(4);
    e3  = ref_rst(3);
    eo4 = 1'b0;
    eo3 = 1'b0;
    chk("abort_busy3", 16'(busy3), 16'd0);
    chk_idle("abort");
    idle_cycles(12);
    convert(777, -1, 0);
    idle_cycles(1);

    // Randomized conversions, some chained back-to-back.
    for (int n = 0; n < 24; n++) begin
      v = int'($urandom_range(0, 1023));
      convert(v, ((n % 3) == 0) ? int'($urandom_range(0, 8)) : -1,
              int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 1) == 0) idle_cycles(1);
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/height_bcd_converter.md
Name: height_bcd_converter

Overview:
- Iterative shift-add-3 (double-dabble) binary-to-BCD converter for the measured height value.
- Sits directly upstream of the per-character glyph stage. It supplies one stable 4-bit decimal digit per display character position.
- Digit outputs are updated only at conversion end, so the display never samples a partial result.

Parameters:
- BIN_WIDTH, 10, width of the binary input value (max 1023 at default).
- NUM_DIGITS, 4, number of BCD digits produced; digit 0 is the least significant.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bin_in; sampled only when busy=0.
- bin_in  input  BIN_WIDTH  unsigned binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; digits/overflow valid and updated in this cycle.
- digits  output  4*NUM_DIGITS  packed BCD, digit i at bits [4i+3:4i]; held between conversions.
- overflow  output  1  last captured value exceeded 10^NUM_DIGITS-1 and was saturated; held with digits.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state=IDLE, busy=0, done=0, overflow=0.
  - digits = all zero (all-blank code when the optional feature is compiled in).
  - Internal shift register and bit counter cleared.
- States: IDLE and CONVERT.
- IDLE -> CONVERT on an edge with start=1.
  - Capture bin_in. If bin_in > 10^NUM_DIGITS-1, capture 10^NUM_DIGITS-1 instead and set the pending-overflow flag.
  - BCD scratch = 0; bit counter = BIN_WIDTH; busy=1 from the next cycle.
- CONVERT, one input bit per cycle:
  - Every BCD nibble >= 5 gets +3.
  - The {scratch, binary} register then shifts left by 1; bit counter decrements.
- CONVERT -> IDLE on the edge where the counter reaches 0 (the BIN_WIDTH-th shift).
  - That same edge loads digits from scratch and overflow from the pending flag.
  - It also sets done=1 and busy=0.
- done is high for exactly one cycle. In every other cycle done=0, and digits/overflow hold their values.
- Latency: the start-accepting edge is edge k. done, busy-low and new digits all appear after edge k+BIN_WIDTH, so there are BIN_WIDTH cycles with busy=1.
- start while busy=1 is ignored (not queued). bin_in changes during CONVERT have no effect.
- start=1 in the done cycle is accepted (busy=0). This gives back-to-back conversions with no idle gap.
- Reset mid-conversion aborts: no done pulse, and digits return to their reset value.
- Nibble arithmetic is 4-bit. The add-3 is applied before each shift and never after the final shift.
- Scratch width is 4*NUM_DIGITS. Saturation guarantees no carry out of the top digit.

Optional Feature:
- Macro: HEIGHT_BCD_LEADING_ZERO_BLANK_EN.
- Defined: at load time, every digit more significant than the highest nonzero digit is replaced by 4'hF, which the glyph stage renders as background.
  - Digit 0 always shows a real digit, so value 0 displays "0".
  - Reset value of digits is all 4'hF.
- Undefined: leading zeros are output as 4'h0, and the reset value is all zero.
- Latency and handshake are identical in both builds.

Test Plan:
- Defaults, reset then start with bin_in=1023 -> busy high for 10 cycles; done pulses 10 edges after accept; digits=16'h1023, overflow=0.
- bin_in=0 -> digits=16'h0000 without the macro, 16'hFFF0 with the macro; done is a single-cycle pulse.
- bin_in=57, then start=1 in the done cycle with bin_in=999 -> first result 16'h0057 (16'hFF57 with macro); second done exactly 10 cycles later with 16'h0999 (16'hF999 with macro).
- Start with 123, pulse start with 456 three cycles later while busy -> second start ignored; single done with 16'h0123.
- NUM_DIGITS=3, bin_in=1000 -> digits=12'h999, overflow=1. A following conversion of 5 -> 12'h005, overflow=0.
- Reset asserted during cycle 4 of CONVERT -> next cycle busy=0, digits at reset value, no done pulse. A new start then converts normally.
